// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Signed ops are run on magnitudes, and the signs are fixed up in a final FIX cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [2:0]       i_mdu_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_busy,
    output logic             o_done
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             r_state, w_next;
    logic [CW-1:0]      r_cnt;
    logic               r_is_div, r_neg_q, r_neg_r, r_dz, r_done;
    logic [WIDTH-1:0]   r_hi, r_lo;
    logic [WIDTH-1:0]   r_opa;      // dividend shifting into quotient (div)
    logic [WIDTH-1:0]   r_opb;      // multiplier shifting right (mul) / divisor (div)
    logic [2*WIDTH-1:0] r_mcand;    // multiplicand shifting left
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH:0]     r_rem;      // extra bit carries the borrow of the trial subtract

    logic               w_idle, w_accept, w_signed, w_sa, w_sb;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b;
    logic [WIDTH:0]     w_shift, w_trial;
    logic [2*WIDTH-1:0] w_prod_res;
    logic [WIDTH-1:0]   w_quo_res, w_rem_res;

    assign w_idle   = (r_state == IDLE);
    assign w_accept = w_idle && i_start && !i_mdu_op[2];
    assign w_signed = !i_mdu_op[0];
    assign w_sa     = w_signed & i_a[WIDTH-1];
    assign w_sb     = w_signed & i_b[WIDTH-1];
    assign w_abs_a  = w_sa ? (~i_a + 1'b1) : i_a;
    assign w_abs_b  = w_sb ? (~i_b + 1'b1) : i_b;

    // Restoring divide step: a set MSB in the trial result means it borrowed, so restore.
    assign w_shift  = {r_rem[WIDTH-1:0], r_opa[WIDTH-1]};
    assign w_trial  = w_shift - {1'b0, r_opb};

    assign w_prod_res = r_neg_q ? (~r_prod + 1'b1) : r_prod;
    // Divide by zero yields an all-ones quotient whatever the signedness, so its sign fix is bypassed.
    assign w_quo_res  = r_dz ? {WIDTH{1'b1}} : (r_neg_q ? (~r_opa + 1'b1) : r_opa);
    assign w_rem_res  = r_neg_r ? (~r_rem[WIDTH-1:0] + 1'b1) : r_rem[WIDTH-1:0];

    assign o_busy = !w_idle;
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

    // State register
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Next-state: WIDTH CALC iterations, then a single FIX cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = CALC;
            CALC:    if (r_cnt == CW'(WIDTH - 1)) w_next = FIX;
            FIX:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: operand latch, iteration, sign fix and HI/LO writeback
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_mcand  <= '0;
            r_prod   <= '0;
            r_rem    <= '0;
        end else begin
            r_done <= (r_state == FIX);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cnt    <= '0;
                        r_is_div <= i_mdu_op[1];
                        r_dz     <= i_mdu_op[1] && (i_b == '0);
                        r_neg_q  <= (w_sa ^ w_sb) && !(i_mdu_op[1] && (i_b == '0));
                        r_neg_r  <= w_sa && i_mdu_op[1];
                        r_opa    <= w_abs_a;
                        r_opb    <= w_abs_b;
                        r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
                        r_prod   <= '0;
                        r_rem    <= '0;
                    end else if (i_start && i_mdu_op == 3'b100) begin
                        r_hi <= i_a;
                    end else if (i_start && i_mdu_op == 3'b101) begin
                        r_lo <= i_a;
                    end
                end
                CALC: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_is_div) begin
                        r_rem <= w_trial[WIDTH] ? w_shift : w_trial;
                        r_opa <= {r_opa[WIDTH-2:0], ~w_trial[WIDTH]};
                    end else begin
                        if (r_opb[0]) r_prod <= r_prod + r_mcand;
                        r_mcand <= r_mcand << 1;
                        r_opb   <= r_opb >> 1;
                    end
                end
                FIX: begin
                    if (r_is_div) begin
                        r_hi <= w_rem_res;
                        r_lo <= w_quo_res;
                    end else begin
                        r_hi <= w_prod_res[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_res[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath. It sits in the execute stage alongside the ALU and is driven by the same decoded control as the ALU control block. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and asserts `busy` so the hazard logic stalls MFHI/MFLO and further MDU ops until results are written.

## Interface
- `WIDTH`, 32, operand and HI/LO width; the iteration count equals `WIDTH`.

- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low; forces the reset state immediately.
- `start` in 1: request; sampled only while `busy`=0.
- `mdu_op` in 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
- `a` in WIDTH: rs operand (multiplicand / dividend / MTHI-MTLO source).
- `b` in WIDTH: rt operand (multiplier / divisor).
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.
- `busy` out 1: high while an iterative op is in flight.
- `done` out 1: one-cycle pulse in the cycle after HI/LO are written by MULT/DIV.

## Operation
- States: IDLE, CALC, FIX. `busy` = (state != IDLE), decoded combinationally from the state register.
- IDLE + `start` + op 000–011:
  - Latch the absolute values of `a` and `b`. Signed ops take two's-complement magnitudes; unsigned ops take them as-is.
  - Latch the negate flags:
    - MULT: product negative = a[31]^b[31].
    - DIV: quotient negative = a[31]^b[31]; remainder negative = a[31].
  - Clear the iteration counter and go to CALC.
- IDLE + `start` + MTHI/MTLO: write `hi`/`lo` = `a` on that edge; stay in IDLE. No `busy`, no `done`.
- IDLE + `start` + op 11x: no effect.
- CALC: one iteration per cycle, counter 0..WIDTH-1; go to FIX after iteration WIDTH-1.
  - Multiply: shift-add into a 2·WIDTH accumulator, LSB-first over the multiplier.
  - Divide: restoring shift-subtract. The remainder register is WIDTH+1 bits to hold the borrow.
- FIX: apply sign correction, write `hi`/`lo`, go to IDLE, assert `done` for the following cycle.
  - Multiply: {hi,lo} = 64-bit product, negated if the flag is set.
  - Divide: lo = quotient, hi = remainder, each negated per its flag.
- Arithmetic: all negation is two's complement modulo 2^WIDTH (multiply modulo 2^(2·WIDTH)); no saturation.
- Divide by zero (b=0, any signedness): runs the full latency; result hi = `a`, lo = 32'hFFFFFFFF.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0. This falls out of the wrap rules; no special casing.
- `start` while `busy`=1 is ignored. Operands are not re-sampled and there is no queueing.
- `hi`/`lo` hold their old values throughout CALC. They change only in FIX or on MTHI/MTLO.

## Timing
- Reset values: state IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, counter 0, flags 0.
- MULT/DIV latency, with E0 as the accepting edge:
  - `busy` rises right after E0 and stays high for exactly WIDTH+1 cycles (E1..E32 CALC, E33 FIX).
  - `hi`/`lo` are valid after E33, and `busy` falls after E33.
  - `done`=1 for the cycle between E33 and E34.
- A new `start` is accepted on E34 at the earliest, i.e. in the same cycle `done` is high. Back-to-back ops are therefore spaced 34 edges apart.
- MTHI/MTLO: result visible the cycle after the accepting edge; a following op may start on the next edge.
- Reset asserted mid-operation: immediately returns to IDLE.
  - `hi`/`lo` are cleared to 0 and no `done` is produced.
  - After deassertion the unit accepts `start` on the first rising edge.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF: `busy` high 33 cycles; hi=0xFFFFFFFE, lo=0x00000001; `done` one cycle.
- MULT a=0xFFFFFFFD (-3), b=7: hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- DIV a=-7 (0xFFFFFFF9), b=2: lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU with the same operands: lo=0x7FFFFFFC, hi=1.
- Division corner cases:
  - DIV a=0x80000000, b=0xFFFFFFFF: lo=0x80000000, hi=0.
  - DIVU a=0x1234, b=0: hi=0x1234, lo=0xFFFFFFFF.
- Busy, reset and move behaviour:
  - Pulse `start` with a DIV mid-CALC of a MULT: the second request is ignored and the MULT result is unchanged.
  - MTHI 0xAAAA5555 in IDLE: hi updates next cycle and `busy` stays 0.
- Assert `reset` low at CALC iteration 10 of a MULT: `busy`, `done`, hi and lo are 0 immediately. After release, a MULTU 3×5 yields hi=0, lo=15.
